// File: rtl/or1200_vlx_getbits.sv
// or1200_vlx_getbits: MSB-first variable-length bit reader for the VLX path.
// Prefetches bytes from data memory through the dcpu port into a 32-bit
// left-justified buffer and serves 1..16-bit get-bits requests from it.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-low reset
//   get_bits_op_i, num_bits_i CPU request strobe and width (0 or >16 -> 16)
//   stall_cpu_o, done_o, dat_o  pipeline hold, result pulse, right-justified result
//   vlx_addr_o, fetch_o       byte fetch address and request
//   ack_i, dat_i              fetch acknowledge and fetched byte
//   spr_cs, spr_write, spr_addr, spr_dat_i, spr_dat_o  SPR window
//     0: read pointer (write restarts the stream), 1: bit count,
//     2: control (bit 0 enable), 3: status {pending, fetch state}
//
// Optional build macro: OR1200_VLX_UNSTUFF_EN drops a 0x00 byte that
// directly follows a 0xFF byte (JPEG byte-stuffing removal).

module or1200_vlx_getbits #(
  parameter int BUF_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        get_bits_op_i,
  input  logic [4:0]  num_bits_i,
  output logic        stall_cpu_o,
  output logic        done_o,
  output logic [31:0] dat_o,
  output logic [31:0] vlx_addr_o,
  output logic        fetch_o,
  input  logic        ack_i,
  input  logic [7:0]  dat_i,
  input  logic        spr_cs,
  input  logic        spr_write,
  input  logic [1:0]  spr_addr,
  input  logic [31:0] spr_dat_i,
  output logic [31:0] spr_dat_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [BUF_W-1:0]  bit_buf;
  logic [5:0]        bit_cnt;
  logic [31:0]       rd_ptr;
  logic              pending;
  logic [4:0]        pend_n;
  logic              enable;
  logic              stale;      // fetch in flight belongs to a discarded stream
  logic [31:0]       dat_q;

`ifdef OR1200_VLX_UNSTUFF_EN
  logic              prev_ff;
`endif

  logic              ptr_wr;
  logic              ctl_wr;
  logic              ack_take;
  logic              stuff_drop;
  logic              serve;
  logic [4:0]        req_n;
  logic [5:0]        take_n;
  logic [5:0]        cnt_after;
  logic [BUF_W-1:0]  buf_shift;
  logic [BUF_W-1:0]  app_buf;
  logic [31:0]       serve_dat;

  assign ptr_wr   = spr_cs & spr_write & (spr_addr == 2'd0);
  assign ctl_wr   = spr_cs & spr_write & (spr_addr == 2'd2);
  assign ack_take = (state == ST_REQ) & ack_i;

`ifdef OR1200_VLX_UNSTUFF_EN
  assign stuff_drop = prev_ff & (dat_i == 8'h00);
`else
  assign stuff_drop = 1'b0;
`endif

  assign req_n = ((num_bits_i == 5'd0) || (num_bits_i > 5'd16)) ? 5'd16 : num_bits_i;

  // A pointer write owns the buffer this cycle; a pending request waits for
  // the new stream instead of consuming bits that are being discarded.
  assign serve = pending & ({1'b0, pend_n} <= bit_cnt) & ~ptr_wr;

  always_comb begin
    take_n    = serve ? {1'b0, pend_n} : 6'd0;
    cnt_after = bit_cnt - take_n;
    buf_shift = bit_buf << take_n;
    // Bits below the valid region are always zero, so OR-ing the byte in
    // at the post-consume position merges serve and append in one cycle.
    app_buf   = buf_shift | ({dat_i, {(BUF_W-8){1'b0}}} >> cnt_after);
    serve_dat = bit_buf >> (6'd32 - {1'b0, pend_n});
  end

  // Fetch FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch FSM next state: room for a whole byte is enough to start a fetch,
  // since the buffer can only drain while the fetch is outstanding.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (enable && (bit_cnt <= 6'd24)) state_nxt = ST_REQ;
      ST_REQ:  if (ack_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Buffer, pointer, request and SPR state
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bit_buf <= '0;
      bit_cnt <= 6'd0;
      rd_ptr  <= 32'd0;
      pending <= 1'b0;
      pend_n  <= 5'd0;
      enable  <= 1'b0;
      stale   <= 1'b0;
      dat_q   <= 32'd0;
`ifdef OR1200_VLX_UNSTUFF_EN
      prev_ff <= 1'b0;
`endif
    end else begin
      if (ptr_wr) begin
        rd_ptr  <= spr_dat_i;
        bit_buf <= '0;
        bit_cnt <= 6'd0;
        // An ack in this same cycle finishes the old fetch; otherwise the
        // byte still to come must be thrown away.
        stale   <= (state == ST_REQ) & ~ack_i;
`ifdef OR1200_VLX_UNSTUFF_EN
        prev_ff <= 1'b0;
`endif
      end else begin
        bit_buf <= buf_shift;
        bit_cnt <= cnt_after;
        if (ack_take) begin
          stale <= 1'b0;
          if (!stale) begin
            rd_ptr <= rd_ptr + 32'd1;
            if (!stuff_drop) begin
              bit_buf <= app_buf;
              bit_cnt <= cnt_after + 6'd8;
            end
`ifdef OR1200_VLX_UNSTUFF_EN
            prev_ff <= stuff_drop ? 1'b0 : (dat_i == 8'hFF);
`endif
          end
        end
      end

      if (serve) begin
        pending <= 1'b0;
        dat_q   <= serve_dat;
      end else if (get_bits_op_i && !pending) begin
        pending <= 1'b1;
        pend_n  <= req_n;
      end

      if (ctl_wr) begin
        enable <= spr_dat_i[0];
      end
    end
  end

  assign done_o      = serve;
  assign dat_o       = serve ? serve_dat : dat_q;
  assign stall_cpu_o = (get_bits_op_i & ~pending) | (pending & ~serve);
  assign fetch_o     = (state == ST_REQ);
  assign vlx_addr_o  = rd_ptr;

  always_comb begin
    spr_dat_o = 32'd0;
    if (spr_cs) begin
      case (spr_addr)
        2'd0:    spr_dat_o = rd_ptr;
        2'd1:    spr_dat_o = {26'd0, bit_cnt};
        2'd2:    spr_dat_o = {31'd0, enable};
        default: spr_dat_o = {30'd0, pending, state};
      endcase
    end
  end

endmodule

// File: tb/tb_or1200_vlx_getbits.sv
// Bench for or1200_vlx_getbits: directed scenarios plus randomized requests
// checked against a bit-queue model of the byte stream.

module tb_or1200_vlx_getbits;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        get_bits_op;
  logic [4:0]  num_bits;
  logic        stall_cpu_o;
  logic        done_o;
  logic [31:0] dat_o;
  logic [31:0] vlx_addr_o;
  logic        fetch_o;
  logic        ack_i;
  logic [7:0]  dat_i;
  logic        spr_cs;
  logic        spr_write;
  logic [1:0]  spr_addr;
  logic [31:0] spr_dat_i;
  logic [31:0] spr_dat_o;

  always #5 clk = ~clk;

  or1200_vlx_getbits #(.BUF_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .get_bits_op_i(get_bits_op), .num_bits_i(num_bits),
    .stall_cpu_o(stall_cpu_o), .done_o(done_o), .dat_o(dat_o),
    .vlx_addr_o(vlx_addr_o), .fetch_o(fetch_o), .ack_i(ack_i), .dat_i(dat_i),
    .spr_cs(spr_cs), .spr_write(spr_write), .spr_addr(spr_addr),
    .spr_dat_i(spr_dat_i), .spr_dat_o(spr_dat_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- memory and stream model ----------------
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h96;
  endfunction

  bit          mq[$];
  logic [31:0] m_ptr;
`ifdef OR1200_VLX_UNSTUFF_EN
  bit          m_ff;
`endif

  task automatic model_reset(input logic [31:0] p);
    mq.delete();
    m_ptr = p;
`ifdef OR1200_VLX_UNSTUFF_EN
    m_ff = 1'b0;
`endif
  endtask

  // Next n bits of the logical byte stream starting at the SPR pointer.
  task automatic model_get(input logic [4:0] n, output logic [31:0] e);
    int k;
    logic [7:0] b;
    k = (n == 5'd0 || n > 5'd16) ? 16 : int'(n);
    while (mq.size() < k) begin
      b = mem_rd(m_ptr);
      m_ptr = m_ptr + 32'd1;
`ifdef OR1200_VLX_UNSTUFF_EN
      if (m_ff && b == 8'h00) begin
        m_ff = 1'b0;
        continue;
      end
      m_ff = (b == 8'hFF);
`endif
      for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
    end
    e = 32'd0;
    for (int i = 0; i < k; i++) e = {e[30:0], mq.pop_front()};
  endtask

  // ---------------- fetch responder ----------------
  int         budget = 0;   // acks allowed; -1 = unlimited
  int         dmax   = 0;
  int         cur_d  = 0;
  int         wcnt   = 0;
  bit         man_req = 1'b0;
  logic [7:0] man_dat = 8'h00;
  int         ack_cyc = 0;

  initial begin
    ack_i = 1'b0;
    dat_i = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (ack_i) begin
        ack_i = 1'b0;
      end else if (man_req) begin
        ack_i   = 1'b1;
        dat_i   = man_dat;
        man_req = 1'b0;
        ack_cyc = cyc;
      end else if (fetch_o && budget != 0) begin
        if (wcnt >= cur_d) begin
          ack_i   = 1'b1;
          dat_i   = mem_rd(vlx_addr_o);
          ack_cyc = cyc;
          wcnt    = 0;
          cur_d   = $urandom_range(dmax, 0);
          if (budget > 0) budget--;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // ---------------- SPR / request tasks ----------------
  task automatic spr_wr(input logic [1:0] a, input logic [31:0] d, output bit stale);
    @(posedge clk); #1;
    spr_cs = 1'b1; spr_write = 1'b1; spr_addr = a; spr_dat_i = d;
    @(negedge clk);
    stale = fetch_o && !ack_i;
    @(posedge clk); #1;
    spr_cs = 1'b0; spr_write = 1'b0;
  endtask

  task automatic spr_rd(input logic [1:0] a, output logic [31:0] v);
    @(posedge clk); #1;
    spr_cs = 1'b1; spr_write = 1'b0; spr_addr = a;
    @(negedge clk);
    v = spr_dat_o;
    @(posedge clk); #1;
    spr_cs = 1'b0;
  endtask

  // Point the reader at p; a fetch left in flight is acked with junk.
  task automatic restart(input logic [31:0] p);
    bit st;
    budget = 0;
    spr_wr(2'd0, p, st);
    model_reset(p);
    if (st) begin
      man_dat = 8'hEE;
      man_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cnt(input int c);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < 60; i++) begin
      spr_rd(2'd1, v);
      if (v == c) break;
    end
    check("wait_cnt", v, c);
  endtask

  task automatic wait_fetch(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fetch_o) begin seen = 1'b1; break; end
    end
    check({tag, "_fetch"}, 32'(seen), 32'd1);
  endtask

  task automatic get(input logic [4:0] n, input string tag, input int exp_lat,
                     output logic [31:0] v);
    logic [31:0] e;
    int lat, bad;
    bit seen;
    model_get(n, e);
    @(posedge clk); #1;
    get_bits_op = 1'b1; num_bits = n;
    @(negedge clk);
    check({tag, "_stall_acc"}, 32'(stall_cpu_o), 32'd1);
    @(posedge clk); #1;
    get_bits_op = 1'b0;
    seen = 1'b0; lat = 0; bad = 0; v = 32'd0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (done_o) begin seen = 1'b1; lat = i; v = dat_o; break; end
      if (!stall_cpu_o) bad++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_stall_wait"}, bad, 0);
    if (seen) begin
      check({tag, "_val"}, v, e);
      check({tag, "_stall_done"}, 32'(stall_cpu_o), 32'd0);
      if (exp_lat > 0) check({tag, "_lat"}, lat, exp_lat);
      @(negedge clk);
      check({tag, "_hold"}, dat_o, v);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired=1 required=0");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] v, e, base, a;
    bit st, seen;
    int bad, d;
    logic [4:0] n;

    rst_i = 1'b0; get_bits_op = 1'b0; num_bits = 5'd0;
    spr_cs = 1'b0; spr_write = 1'b0; spr_addr = 2'd0; spr_dat_i = 32'd0;
    model_reset(32'd0);

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    @(negedge clk);
    check("rst_fetch", 32'(fetch_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_stall", 32'(stall_cpu_o), 0);
    check("rst_dat", dat_o, 0);
    check("rst_addr", vlx_addr_o, 0);
    check("rst_spr_idle", spr_dat_o, 0);
    spr_rd(2'd1, v); check("rst_cnt", v, 0);
    spr_rd(2'd2, v); check("rst_ctl", v, 0);
    spr_rd(2'd3, v); check("rst_status", v, 0);
    repeat (4) @(negedge clk);
    check("dis_nofetch", 32'(fetch_o), 0);

    // Basic MSB-first extraction with a full buffer
    spr_wr(2'd2, 32'd1, st);
    mem[32'h1000] = 8'hA5; mem[32'h1001] = 8'h3C;
    restart(32'h1000);
    budget = -1;
    wait_cnt(32);
    get(5'd4, "t1a", 1, v); check("t1a_lit", v, 32'hA);
    get(5'd8, "t1b", 1, v); check("t1b_lit", v, 32'h53);
    get(5'd4, "t1c", 1, v); check("t1c_lit", v, 32'hC);

    // Byte stuffing
    mem[32'h1000] = 8'hFF; mem[32'h1001] = 8'h00; mem[32'h1002] = 8'h81;
    restart(32'h1000);
    budget = 3;
    get(5'd16, "t2", -1, v);
`ifdef OR1200_VLX_UNSTUFF_EN
    check("t2_lit", v, 32'hFF81);
`else
    check("t2_lit", v, 32'hFF00);
`endif
    repeat (20) @(posedge clk);
    spr_rd(2'd0, v); check("t2_ptr", v, 32'h1003);

    // Miss held off by a slow ack
    mem[32'h5000] = 8'hC3; mem[32'h5001] = 8'h7E;
    restart(32'h5000);
    budget = 1;
    wait_cnt(8);
    model_get(5'd12, e);
    @(posedge clk); #1; get_bits_op = 1'b1; num_bits = 5'd12;
    @(negedge clk); check("t3_stall_acc", 32'(stall_cpu_o), 1);
    @(posedge clk); #1; get_bits_op = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!stall_cpu_o || done_o) bad++;
    end
    check("t3_held", bad, 0);
    @(posedge clk); #1; budget = 1;
    seen = 1'b0; d = 0; v = 32'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_o) begin seen = 1'b1; v = dat_o; d = cyc - ack_cyc; break; end
    end
    check("t3_done_seen", 32'(seen), 1);
    check("t3_val", v, e);
    check("t3_lit", v, 32'hC37);
    check("t3_ack_to_done", d, 1);

    // Serve and append in the same cycle
    mem[32'h4000] = 8'h11; mem[32'h4001] = 8'h22;
    mem[32'h4002] = 8'h33; mem[32'h4003] = 8'h5A;
    restart(32'h4000);
    budget = 3;
    wait_cnt(24);
    wait_fetch("t4");
    check("t4_addr", vlx_addr_o, 32'h4003);
    model_get(5'd16, e);
    @(posedge clk); #1; get_bits_op = 1'b1; num_bits = 5'd16;
    @(posedge clk); #1; get_bits_op = 1'b0; man_dat = 8'h5A; man_req = 1'b1;
    @(negedge clk);
    check("t4_ack", 32'(ack_i), 1);
    check("t4_done", 32'(done_o), 1);
    check("t4_val", dat_o, e);
    check("t4_lit", dat_o, 32'h1122);
    spr_rd(2'd1, v); check("t4_cnt", v, 16);
    get(5'd16, "t4b", 1, v); check("t4b_lit", v, 32'h335A);

    // Randomized requests across the 2^32 pointer wrap
    base = 32'hFFFF_FFF0;
    for (int i = 0; i < 600; i++) begin
      a = base + 32'(i);
      if ($urandom_range(7, 0) == 0) begin
        mem[a] = 8'hFF;
        mem[a + 32'd1] = 8'h00;
        i++;
      end else begin
        mem[a] = 8'($urandom);
      end
    end
    dmax = 3;
    restart(base);
    budget = -1;
    for (int r = 0; r < 60; r++) begin
      n = 5'($urandom_range(31, 0));
      get(n, "rnd", -1, v);
      repeat ($urandom_range(4, 0)) @(posedge clk);
    end
    spr_rd(2'd0, v);
    check("rnd_wrapped", 32'(v < 32'h0000_0200), 1);

    // Pointer write while a fetch is outstanding
    dmax = 0; cur_d = 0;
    budget = 0;
    repeat (4) @(posedge clk);
    wait_fetch("t5a");
    mem[32'h2000] = 8'h6B;
    spr_wr(2'd0, 32'h2000, st);
    check("t5_in_req", 32'(st), 1);
    model_reset(32'h2000);
    man_dat = 8'h77; man_req = 1'b1;
    repeat (2) @(posedge clk);
    spr_rd(2'd1, v); check("t5_cnt", v, 0);
    wait_fetch("t5b");
    check("t5_addr", vlx_addr_o, 32'h2000);
    budget = -1;
    get(5'd8, "t5", -1, v); check("t5_lit", v, 32'h6B);

    // Reset pulse in the middle of a fetch, followed by a late ack
    budget = 0;
    repeat (4) @(posedge clk);
    wait_fetch("t6");
    @(posedge clk); #1; rst_i = 1'b0;
    @(posedge clk); #1; rst_i = 1'b1; man_dat = 8'hAB; man_req = 1'b1;
    @(negedge clk);
    check("t6_fetch", 32'(fetch_o), 0);
    check("t6_done", 32'(done_o), 0);
    check("t6_stall", 32'(stall_cpu_o), 0);
    check("t6_dat", dat_o, 0);
    check("t6_addr", vlx_addr_o, 0);
    check("t6_spr_idle", spr_dat_o, 0);
    repeat (3) @(negedge clk);
    check("t6_nofetch", 32'(fetch_o), 0);
    spr_rd(2'd1, v); check("t6_cnt", v, 0);
    spr_rd(2'd0, v); check("t6_ptr", v, 0);
    spr_rd(2'd3, v); check("t6_status", v, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
